// File: rtl/burst_adr_gen.sv
// Wishbone burst address generator: loads a start address and cycle/burst type,
// then steps the beat address (linear, wrap4/8/16 or constant) on each accepted inc.
module burst_adr_gen #(
    parameter int ADR_W    = 24,
    parameter int PAGE_W   = 4,
    parameter int INIT_DLY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADR_W-1:0]  adr_i,
    input  logic [2:0]        cti_i,
    input  logic [1:0]        bte_i,
    input  logic              init,
    input  logic              inc,
    input  logic              abort,
    output logic [ADR_W-1:0]  adr_o,
    output logic              last,
    output logic              done,
    output logic              busy,
    output logic [PAGE_W:0]   beat_o
);

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    logic             init_q;
    logic             load;
    bte_e             bte_q;
    logic             const_q;
    logic [PAGE_W:0]  remaining;
    logic [PAGE_W:0]  n_beats;
    logic [ADR_W-1:0] next_adr;

    assign load = (INIT_DLY == 0) ? init : init_q;

    // Linear bursts stop at the page boundary, so N is the words left in the page.
    always_comb begin
        n_beats = (PAGE_W+1)'(1);
        if (cti_i != 3'b000 && cti_i != 3'b111) begin
            case (bte_e'(bte_i))
                BTE_WRAP4:  n_beats = (PAGE_W+1)'(4);
                BTE_WRAP8:  n_beats = (PAGE_W+1)'(8);
                BTE_WRAP16: n_beats = (PAGE_W+1)'(16);
                default:    n_beats = ((PAGE_W+1)'(1) << PAGE_W)
                                      - {1'b0, adr_i[PAGE_W-1:0]};
            endcase
        end
    end

    always_comb begin
        next_adr = adr_o;
        if (!const_q) begin
            case (bte_q)
                BTE_WRAP4:  next_adr[1:0] = adr_o[1:0] + 2'd1;
                BTE_WRAP8:  next_adr[2:0] = adr_o[2:0] + 3'd1;
                BTE_WRAP16: next_adr[3:0] = adr_o[3:0] + 4'd1;
                default:    next_adr      = adr_o + ADR_W'(1);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q    <= 1'b0;
            adr_o     <= '0;
            last      <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            beat_o    <= '0;
            bte_q     <= BTE_LINEAR;
            const_q   <= 1'b0;
            remaining <= '0;
        end else begin
            init_q <= init;
            if (load) begin
                adr_o     <= adr_i;
                bte_q     <= bte_e'(bte_i);
                const_q   <= (cti_i == 3'b001);
                remaining <= n_beats - (PAGE_W+1)'(1);
                beat_o    <= '0;
                busy      <= 1'b1;
                done      <= 1'b0;
                last      <= (n_beats == (PAGE_W+1)'(1));
            end else if (abort && busy) begin
                done <= 1'b1;
                busy <= 1'b0;
                last <= 1'b0;
            end else if (inc && busy) begin
                beat_o <= beat_o + (PAGE_W+1)'(1);
                if (last) begin
                    last <= 1'b0;
                    done <= 1'b1;
                    busy <= 1'b0;
                end else begin
                    remaining <= remaining - (PAGE_W+1)'(1);
                    last      <= (remaining == (PAGE_W+1)'(1));
                    adr_o     <= next_adr;
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_adr_gen.sv
// Directed bench for burst_adr_gen (ADR_W=8, PAGE_W=4); a second INIT_DLY=0
// instance shares the inputs and is only checked for load timing.
module tb_burst_adr_gen;

    logic       clk;
    logic       rst_n;
    logic [7:0] adr_i;
    logic [2:0] cti_i;
    logic [1:0] bte_i;
    logic       init;
    logic       inc;
    logic       abort;
    logic [7:0] adr_o,  adr_o0;
    logic       last,   last0;
    logic       done,   done0;
    logic       busy,   busy0;
    logic [4:0] beat_o, beat_o0;

    int n_cmp = 0;
    int n_err = 0;

    burst_adr_gen #(.ADR_W(8), .PAGE_W(4), .INIT_DLY(1)) dut (
        .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .cti_i(cti_i), .bte_i(bte_i),
        .init(init), .inc(inc), .abort(abort),
        .adr_o(adr_o), .last(last), .done(done), .busy(busy), .beat_o(beat_o)
    );

    burst_adr_gen #(.ADR_W(8), .PAGE_W(4), .INIT_DLY(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .adr_i(adr_i), .cti_i(cti_i), .bte_i(bte_i),
        .init(init), .inc(inc), .abort(abort),
        .adr_o(adr_o0), .last(last0), .done(done0), .busy(busy0), .beat_o(beat_o0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked at the next falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [7:0] a, input logic l,
                           input logic d, input logic b, input logic [4:0] n);
        chk({tag, ".adr"},  {24'h0, adr_o}, {24'h0, a});
        chk({tag, ".last"}, {31'h0, last},  {31'h0, l});
        chk({tag, ".done"}, {31'h0, done},  {31'h0, d});
        chk({tag, ".busy"}, {31'h0, busy},  {31'h0, b});
        chk({tag, ".beat"}, {27'h0, beat_o}, {27'h0, n});
    endtask

    task automatic do_load(input logic [7:0] a, input logic [2:0] c, input logic [1:0] b);
        adr_i = a; cti_i = c; bte_i = b; init = 1'b1;
        tick();
        init = 1'b0;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; adr_i = '0; cti_i = '0; bte_i = '0;
        init = 1'b0; inc = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);

        // Wrap4 at 0x0E, also checks init-to-load latency of both variants
        adr_i = 8'h0E; cti_i = 3'b010; bte_i = 2'b01; init = 1'b1;
        tick();
        chk("dly1.not_yet", {24'h0, adr_o},  32'h00);
        chk("dly0.loaded",  {24'h0, adr_o0}, 32'h0E);
        init = 1'b0;
        tick();
        chk_all("w4.load", 8'h0E, 1'b0, 1'b0, 1'b1, 5'd0);
        inc = 1'b1;
        tick(); chk_all("w4.i1", 8'h0F, 1'b0, 1'b0, 1'b1, 5'd1);
        tick(); chk_all("w4.i2", 8'h0C, 1'b0, 1'b0, 1'b1, 5'd2);
        tick(); chk_all("w4.i3", 8'h0D, 1'b1, 1'b0, 1'b1, 5'd3);
        tick(); chk_all("w4.done", 8'h0D, 1'b0, 1'b1, 1'b0, 5'd4);
        tick(); chk_all("w4.idle_inc", 8'h0D, 1'b0, 1'b1, 1'b0, 5'd4);
        inc = 1'b0;

        // Linear at 0x3D: three words to the page end
        do_load(8'h3D, 3'b010, 2'b00);
        chk_all("lin.load", 8'h3D, 1'b0, 1'b0, 1'b1, 5'd0);
        inc = 1'b1;
        tick(); chk_all("lin.i1", 8'h3E, 1'b0, 1'b0, 1'b1, 5'd1);
        tick(); chk_all("lin.i2", 8'h3F, 1'b1, 1'b0, 1'b1, 5'd2);
        tick(); chk_all("lin.done", 8'h3F, 1'b0, 1'b1, 1'b0, 5'd3);
        tick(); chk_all("lin.extra", 8'h3F, 1'b0, 1'b1, 1'b0, 5'd3);
        inc = 1'b0;

        // Classic single beat
        do_load(8'h55, 3'b000, 2'b01);
        chk_all("cls.load", 8'h55, 1'b1, 1'b0, 1'b1, 5'd0);
        inc = 1'b1;
        tick(); chk_all("cls.done", 8'h55, 1'b0, 1'b1, 1'b0, 5'd1);
        inc = 1'b0;

        // Constant address, wrap8 length
        do_load(8'h20, 3'b001, 2'b10);
        chk_all("cst.load", 8'h20, 1'b0, 1'b0, 1'b1, 5'd0);
        inc = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk_all("cst.beat", 8'h20, (i == 7), 1'b0, 1'b1, 5'(i));
        end
        tick(); chk_all("cst.done", 8'h20, 1'b0, 1'b1, 1'b0, 5'd8);
        inc = 1'b0;

        // Abort beats a simultaneous inc; abort while idle is ignored
        do_load(8'h25, 3'b010, 2'b10);
        inc = 1'b1;
        tick(); tick();
        chk_all("ab.pre", 8'h27, 1'b0, 1'b0, 1'b1, 5'd2);
        abort = 1'b1;
        tick(); chk_all("ab.hit", 8'h27, 1'b0, 1'b1, 1'b0, 5'd2);
        inc = 1'b0;
        tick(); chk_all("ab.idle", 8'h27, 1'b0, 1'b1, 1'b0, 5'd2);
        abort = 1'b0;

        // Restart mid-burst, then init held high with inc active
        do_load(8'h31, 3'b010, 2'b11);
        inc = 1'b1;
        tick(); tick();
        chk_all("rs.pre", 8'h33, 1'b0, 1'b0, 1'b1, 5'd2);
        inc = 1'b0;
        do_load(8'h80, 3'b010, 2'b00);
        chk_all("rs.load", 8'h80, 1'b0, 1'b0, 1'b1, 5'd0);
        init = 1'b1; inc = 1'b1;
        tick(); chk_all("hold.e1", 8'h81, 1'b0, 1'b0, 1'b1, 5'd1);
        tick(); chk_all("hold.e2", 8'h80, 1'b0, 1'b0, 1'b1, 5'd0);
        init = 1'b0;
        tick(); chk_all("hold.e3", 8'h80, 1'b0, 1'b0, 1'b1, 5'd0);
        tick(); chk_all("hold.e4", 8'h81, 1'b0, 1'b0, 1'b1, 5'd1);
        inc = 1'b0;

        // Asynchronous reset mid-wrap16
        do_load(8'h4A, 3'b010, 2'b11);
        inc = 1'b1;
        tick(); tick();
        chk_all("w16.pre", 8'h4C, 1'b0, 1'b0, 1'b1, 5'd2);
        inc = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("arst", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        @(negedge clk);
        rst_n = 1'b1; inc = 1'b1;
        tick(); chk_all("arst.inc", 8'h00, 1'b0, 1'b0, 1'b0, 5'd0);
        inc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
